wb_write_buffer: RTL and testbench
==================================

# wb_write_buffer

Write-back buffer between the pipeline's WB stage and the register file's single write port. It queues up to DEPTH register write requests, drains one per cycle through the write interface (RegWrite/rd/WriteData), and holds writes back while the port is stalled. Readers can look up the youngest pending write to their source registers so decode never sees a stale value.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- AW, 5, register address width
- DW, 32, data width
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- push  in  1  WB write request valid this cycle
- push_rd  in  AW  destination register of request
- push_data  in  DW  data of request
- wr_stall  in  1  register-file write port unavailable this cycle
- RegWrite  out  1  write enable to register file
- rd  out  AW  write address to register file
- WriteData  out  DW  write data to register file
- rs_a, rs_b  in  AW  lookup addresses (decode read ports)
- hit_a, hit_b  out  1  pending write found for rs_a / rs_b
- fwd_a, fwd_b  out  DW  data of youngest pending write to rs_a / rs_b
- count  out  $clog2(DEPTH)+1  occupied entries
- full, empty  out  1  count==DEPTH / count==0
- overflow  out  1  sticky: a request was dropped for lack of space

## Operation
- Circular queue: wr_ptr, rd_ptr ($clog2(DEPTH) bits, natural wrap), count, per-entry valid/rd/data.
- accept = push && push_rd!=0 && (!full || pop). Requests to register 0 are discarded silently, never enqueued, never set overflow.
- pop = !empty && !wr_stall.
- RegWrite = pop. rd/WriteData = head entry when !empty; 0 when empty. All three derive only from registered state (no combinational path from push*).
- Register file samples on negedge, so the head is written mid-cycle and removed at the following posedge.
- Simultaneous accept and pop: count unchanged, both pointers advance; legal when full (slot freed by pop is reused).
- push && push_rd!=0 && full && !pop: request dropped, overflow←1, held until reset.
- Duplicate addresses allowed; entries drain in order, so the last write to an address wins in the register file.
- Lookup (combinational): hit_x=1 iff some valid stored entry has rd==rs_x and rs_x!=0; fwd_x = data of the youngest such entry (nearest to wr_ptr); fwd_x=0 when !hit_x. The request being pushed in the current cycle is not visible to lookup; the head being written this cycle remains visible until it pops.

## Timing
- Reset (async assert, sync-safe release): wr_ptr=rd_ptr=0, count=0, all valid=0, overflow=0 → RegWrite=0, rd=0, WriteData=0, empty=1, full=0, hit_a/b=0, fwd_a/b=0.
- Reset mid-operation: all queued writes lost, no further RegWrite until a new push.
- Latency: request accepted at posedge k appears on rd/WriteData after posedge k; RegWrite in cycle k+1 if wr_stall=0; it is written at the negedge of cycle k+1 and removed at posedge k+2.
- Throughput: one write per cycle sustained; with push every cycle and no stalls, count stays ≤1.
- wr_stall only blocks drain; accept continues until full.

## Test plan
- Reset: assert rst_n=0 mid-stream with count=3 → all outputs at reset values immediately (before the next clk edge); after release, RegWrite=0 until a push.
- Single write: push rd=5, data=0xDEADBEEF with wr_stall=0 → next cycle RegWrite=1, rd=5, WriteData=0xDEADBEEF; following cycle empty=1, RegWrite=0.
- Fill/overflow: wr_stall=1, push rd=1..5 with data 0x11..0x55 → after 4 pushes full=1, count=4; 5th dropped, overflow=1; release stall → writes 1,2,3,4 on four consecutive cycles, overflow stays 1.
- Full with concurrent pop: full, wr_stall=0, push rd=9 data 0x99 → accepted, count stays 4, rd=9 drained last.
- Bypass: stall, push rd=7 data 0xA, then rd=7 data 0xB, then rd=3 data 0xC; rs_a=7, rs_b=3 → hit_a=1, fwd_a=0xB, hit_b=1, fwd_b=0xC; rs_a=0 → hit_a=0, fwd_a=0.
- R0 discard: push rd=0 data 0xFFFFFFFF (empty and full cases) → no enqueue, count unchanged, overflow unchanged, no RegWrite.

Source files
------------

// File: rtl/wb_write_buffer.sv
// rtl/wb_write_buffer.sv - register write-back queue with youngest-entry lookup for decode
module wb_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [AW-1:0]              push_rd,
    input  logic [DW-1:0]              push_data,
    input  logic                       wr_stall,
    output logic                       RegWrite,
    output logic [AW-1:0]              rd,
    output logic [DW-1:0]              WriteData,
    input  logic [AW-1:0]              rs_a,
    input  logic [AW-1:0]              rs_b,
    output logic                       hit_a,
    output logic                       hit_b,
    output logic [DW-1:0]              fwd_a,
    output logic [DW-1:0]              fwd_b,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    ent_rd_q   [DEPTH];
    logic [AW-1:0]    ent_rd_d   [DEPTH];
    logic [DW-1:0]    ent_data_q [DEPTH];
    logic [DW-1:0]    ent_data_d [DEPTH];
    logic             overflow_q, overflow_d;

    logic             pop;
    logic             accept;
    logic             drop;
    logic [PW-1:0]    lk_idx;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign overflow = overflow_q;

    // Writes to r0 are architecturally meaningless, so they never occupy a slot.
    assign pop    = !empty && !wr_stall;
    assign accept = push && (push_rd != '0) && (!full || pop);
    assign drop   = push && (push_rd != '0) && full && !pop;

    // Register-file port is driven purely from stored state; the head is written on negedge.
    assign RegWrite  = pop;
    assign rd        = empty ? '0 : ent_rd_q[rd_ptr_q];
    assign WriteData = empty ? '0 : ent_data_q[rd_ptr_q];

    // Queue bookkeeping; pop clears before accept sets so a full-queue slot can be reused.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        valid_d    = valid_q;
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        overflow_d = overflow_q | drop;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (accept) begin
            valid_d[wr_ptr_q]    = 1'b1;
            ent_rd_d[wr_ptr_q]   = push_rd;
            ent_data_d[wr_ptr_q] = push_data;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Lookup scans oldest to youngest so the last match (nearest wr_ptr) wins.
    always_comb begin
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        fwd_a  = '0;
        fwd_b  = '0;
        lk_idx = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = rd_ptr_q + PW'(i);
            if (valid_q[lk_idx] && (rs_a != '0) && (ent_rd_q[lk_idx] == rs_a)) begin
                hit_a = 1'b1;
                fwd_a = ent_data_q[lk_idx];
            end
            if (valid_q[lk_idx] && (rs_b != '0) && (ent_rd_q[lk_idx] == rs_b)) begin
                hit_b = 1'b1;
                fwd_b = ent_data_q[lk_idx];
            end
        end
    end

    // State register with asynchronous clear of every queued write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd_q[i]   <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            ent_rd_q   <= ent_rd_d;
            ent_data_q <= ent_data_d;
        end
    end

endmodule

// File: tb/tb_wb_write_buffer.sv
// tb/tb_wb_write_buffer.sv - randomized and directed check of wb_write_buffer against a queue model
`timescale 1ns/1ps
module tb_wb_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0;
    logic [AW-1:0] push_rd = '0;
    logic [DW-1:0] push_data = '0;
    logic          wr_stall = 1'b0;
    logic          RegWrite;
    logic [AW-1:0] rd;
    logic [DW-1:0] WriteData;
    logic [AW-1:0] rs_a = '0;
    logic [AW-1:0] rs_b = '0;
    logic          hit_a, hit_b;
    logic [DW-1:0] fwd_a, fwd_b;
    logic [2:0]    count;
    logic          full, empty, overflow;

    wb_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_rd(push_rd), .push_data(push_data),
        .wr_stall(wr_stall), .RegWrite(RegWrite), .rd(rd), .WriteData(WriteData),
        .rs_a(rs_a), .rs_b(rs_b), .hit_a(hit_a), .hit_b(hit_b), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .count(count), .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q[$];
    bit   m_ovf;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Youngest pending write to rs: last match scanning the queue front to back.
    function automatic logic [DW:0] look(input logic [AW-1:0] rs);
        logic [DW:0] r = '0;
        if (rs != '0)
            foreach (q[i]) if (q[i].r == rs) r = {1'b1, q[i].d};
        return r;
    endfunction

    task automatic drive(input logic p, input logic [AW-1:0] r, input logic [DW-1:0] d,
                         input logic st, input logic [AW-1:0] a, input logic [AW-1:0] b);
        push = p; push_rd = r; push_data = d; wr_stall = st; rs_a = a; rs_b = b;
        #2;
    endtask

    task automatic cmp_model();
        logic        pop;
        ent_t        head;
        logic [DW:0] la, lb;
        pop  = (q.size() > 0) && !wr_stall;
        head = (q.size() > 0) ? q[0] : '0;
        la   = look(rs_a);
        lb   = look(rs_b);
        check("regwrite", RegWrite, pop);
        check("rd", rd, head.r);
        check("wdata", WriteData, head.d);
        check("count", count, q.size());
        check("full", full, q.size() == DEPTH);
        check("empty", empty, q.size() == 0);
        check("overflow", overflow, m_ovf);
        check("hit_a", hit_a, la[DW]);
        check("fwd_a", fwd_a, la[DW-1:0]);
        check("hit_b", hit_b, lb[DW]);
        check("fwd_b", fwd_b, lb[DW-1:0]);
    endtask

    task automatic step();
        bit pop, acc, valid_req;
        ent_t e;
        valid_req = push && (push_rd != '0);
        pop = (q.size() > 0) && !wr_stall;
        acc = valid_req && ((q.size() < DEPTH) || pop);
        if (valid_req && !acc) m_ovf = 1'b1;
        e.r = push_rd;
        e.d = push_data;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
        #1;
    endtask

    task automatic cyc(input logic p, input logic [AW-1:0] r, input logic [DW-1:0] d,
                       input logic st, input logic [AW-1:0] a, input logic [AW-1:0] b);
        drive(p, r, d, st, a, b);
        cmp_model();
        step();
    endtask

    initial begin
        #2;
        cmp_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset in the middle of a drain with three entries queued
        for (int i = 1; i <= 3; i++) cyc(1, AW'(i), DW'(i * 16'h0101), 1, 0, 0);
        drive(0, 0, 0, 0, 1, 2);
        cmp_model();
        rst_n = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        cmp_model();
        check("rst_count", count, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 2);
            check("rst_no_wr", RegWrite, 0);
            cmp_model();
            step();
        end

        // single write
        cyc(1, 5, 32'hDEADBEEF, 0, 5, 0);
        drive(0, 0, 0, 0, 5, 0);
        check("single_we", RegWrite, 1);
        check("single_rd", rd, 5);
        check("single_wd", WriteData, 32'hDEADBEEF);
        cmp_model();
        step();
        drive(0, 0, 0, 0, 5, 0);
        check("single_empty", empty, 1);
        cmp_model();
        step();

        // r0 on an empty queue
        cyc(1, 0, 32'hFFFFFFFF, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("r0_empty_cnt", count, 0);
        check("r0_empty_we", RegWrite, 0);
        cmp_model();
        step();

        // bypass: youngest duplicate wins, rs=0 never hits
        cyc(1, 7, 32'hA, 1, 0, 0);
        cyc(1, 7, 32'hB, 1, 0, 0);
        cyc(1, 3, 32'hC, 1, 0, 0);
        drive(0, 0, 0, 1, 7, 3);
        check("byp_hit_a", hit_a, 1);
        check("byp_fwd_a", fwd_a, 32'hB);
        check("byp_hit_b", hit_b, 1);
        check("byp_fwd_b", fwd_b, 32'hC);
        cmp_model();
        step();
        drive(0, 0, 0, 1, 0, 3);
        check("byp_r0_hit", hit_a, 0);
        check("byp_r0_fwd", fwd_a, 0);
        cmp_model();
        step();
        while (q.size() > 0) cyc(0, 0, 0, 0, 7, 3);

        // fill, r0 on full, overflow, then drain in order
        for (int i = 1; i <= 4; i++) cyc(1, AW'(i), DW'(i * 8'h11), 1, 2, 4);
        cyc(1, 0, 32'hFFFFFFFF, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        check("fill_full", full, 1);
        check("fill_count", count, 4);
        check("r0_full_ovf", overflow, 0);
        cmp_model();
        step();
        cyc(1, 5, 32'h55, 1, 5, 0);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 0, 5, 1);
            check("drain_we", RegWrite, 1);
            check("drain_rd", rd, i);
            check("drain_ovf", overflow, 1);
            cmp_model();
            step();
        end

        // full with concurrent pop reuses the freed slot
        for (int i = 10; i <= 13; i++) cyc(1, AW'(i), DW'(i), 1, 9, 10);
        drive(1, 9, 32'h99, 0, 9, 0);
        cmp_model();
        step();
        drive(0, 0, 0, 1, 9, 0);
        check("fullpop_cnt", count, 4);
        check("fullpop_hit", hit_a, 1);
        cmp_model();
        step();
        while (q.size() > 0) cyc(0, 0, 0, 0, 9, 13);

        // randomized traffic with alternating stall-heavy and stall-light phases
        for (int i = 0; i < 600; i++) begin
            logic st;
            st = ((i / 40) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            cyc($urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)), $urandom, st,
                AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        while (q.size() > 0) cyc(0, 0, 0, 0, 1, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
